// File: rtl/adder_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// adder_seq_ctrl_pkg
// Shared definitions for the adder sequencing stage: default operand width,
// FSM state encoding and the operand-counter width helper.
// ----------------------------------------------------------------------------
package adder_seq_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Bits needed to hold an operand count from 0 up to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// adder_seq_ctrl
// Sequencing stage in front of an external combinational ripple-carry adder.
// Accepts NUM_OPERANDS operands over a valid/ready handshake, accumulates them
// (add or two's-complement subtract) through the adder, then holds the final
// sum plus carry / sticky signed-overflow flags until downstream acknowledges.
//
// Ports
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   din, din_sub, din_valid : operand, subtract qualifier, operand present
//   din_ready               : operand can be accepted this cycle
//   add_a, add_b, add_cin   : drive the external adder
//   add_s, add_cout         : adder sum and per-stage carries (same cycle)
//   result, carry_flag,
//   ovf_flag, result_valid  : final accumulation and flags
//   result_ack              : downstream has taken the result
// ----------------------------------------------------------------------------
module adder_seq_ctrl
    import adder_seq_ctrl_pkg::*;
#(
    parameter int WIDTH        = WIDTH_DEF,
    parameter int NUM_OPERANDS = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_sub,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_s,
    input  logic [WIDTH-1:0] add_cout,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             result_valid,
    input  logic             result_ack
);

    localparam int CW = cnt_width(NUM_OPERANDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPERANDS - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    logic             accept;

    // Subtraction as a + ~din + 1. add_cin follows din_sub unconditionally;
    // that is harmless because nothing is accepted without din_valid.
    assign add_a   = acc_q;
    assign add_b   = din_sub ? ~din : din;
    assign add_cin = din_sub;

    assign accept  = din_valid & ready_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        ready_d = ready_q;

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    acc_d   = add_s;
                    count_d = count_q + CW'(1);
                    carry_d = add_cout[WIDTH-1];
                    // Signed overflow: carry into MSB differs from carry out.
                    ovf_d   = ovf_q | (add_cout[WIDTH-1] ^ add_cout[WIDTH-2]);
                    if (count_q == LAST_IDX) begin
                        state_d = DONE;
                        valid_d = 1'b1;
                        ready_d = 1'b0;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            DONE: begin
                if (result_ack) begin
                    // carry_flag holds; the rest restarts for the next result.
                    state_d = IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
                valid_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign din_ready    = ready_q;
    assign result       = acc_q;
    assign carry_flag   = carry_q;
    assign ovf_flag     = ovf_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adder_seq_ctrl
// Three instances (NUM_OPERANDS = 2, 3, 1) each paired with a behavioural
// ripple-carry adder. A single negedge process compares DUT outputs against an
// integer-arithmetic reference model and a result scoreboard, then advances
// the model with the inputs the next rising edge will sample.
// ----------------------------------------------------------------------------
module tb_adder_seq_ctrl;

    localparam int NI = 3;

    function automatic int n_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 1);
    endfunction

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic [3:0] din_s     [NI];
    logic       sub_s     [NI];
    logic       valid_s   [NI];
    logic       ready_s   [NI];
    logic [3:0] add_a_s   [NI];
    logic [3:0] add_b_s   [NI];
    logic       add_cin_s [NI];
    logic [3:0] result_s  [NI];
    logic       carry_s   [NI];
    logic       ovf_s     [NI];
    logic       rvalid_s  [NI];
    logic       ack_s     [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [3:0] s_l;
        logic [3:0] co_l;

        // Behavioural 4-bit ripple-carry adder sitting beside the DUT.
        always_comb begin
            logic c;
            s_l  = '0;
            co_l = '0;
            c    = add_cin_s[gi];
            for (int k = 0; k < 4; k++) begin
                s_l[k]  = add_a_s[gi][k] ^ add_b_s[gi][k] ^ c;
                c       = (add_a_s[gi][k] & add_b_s[gi][k]) | (c & (add_a_s[gi][k] ^ add_b_s[gi][k]));
                co_l[k] = c;
            end
        end

        adder_seq_ctrl #(
            .WIDTH        (4),
            .NUM_OPERANDS (n_of(gi))
        ) u_dut (
            .clock        (clk),
            .reset        (reset),
            .din          (din_s[gi]),
            .din_sub      (sub_s[gi]),
            .din_valid    (valid_s[gi]),
            .din_ready    (ready_s[gi]),
            .add_a        (add_a_s[gi]),
            .add_b        (add_b_s[gi]),
            .add_cin      (add_cin_s[gi]),
            .add_s        (s_l),
            .add_cout     (co_l),
            .result       (result_s[gi]),
            .carry_flag   (carry_s[gi]),
            .ovf_flag     (ovf_s[gi]),
            .result_valid (rvalid_s[gi]),
            .result_ack   (ack_s[gi])
        );
    end

    // ------------------------------------------------------------------
    // Reference model + scoreboard + monitor (single process)
    // ------------------------------------------------------------------
    typedef struct {
        int inst;
        int res;
        int car;
        int ovf;
    } exp_t;

    exp_t sb_q[$];

    int  errors = 0;
    int  checks = 0;
    int  m_acc  [NI];
    int  m_cnt  [NI];
    int  m_car  [NI];
    int  m_ovf  [NI];
    bit  m_done [NI];
    bit  prev_v [NI];
    bit  rst_chk = 1'b0;
    bit  armed   = 1'b0;
    bit  fin_req = 1'b0;
    bit  fin_done = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < NI; i++) begin
                if (rst_chk) begin
                    chk($sformatf("u%0d reset result", i), int'(result_s[i]), 0);
                    chk($sformatf("u%0d reset carry", i), int'(carry_s[i]), 0);
                    chk($sformatf("u%0d reset ovf", i), int'(ovf_s[i]), 0);
                end
                chk($sformatf("u%0d din_ready", i), int'(ready_s[i]), m_done[i] ? 0 : 1);
                chk($sformatf("u%0d result_valid", i), int'(rvalid_s[i]), m_done[i] ? 1 : 0);
                if (m_done[i]) begin
                    chk($sformatf("u%0d held result", i), int'(result_s[i]), m_acc[i]);
                    chk($sformatf("u%0d held carry", i), int'(carry_s[i]), m_car[i]);
                    chk($sformatf("u%0d held ovf", i), int'(ovf_s[i]), m_ovf[i]);
                end
                if (rvalid_s[i] === 1'b1 && !prev_v[i]) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL u%0d unexpected result_valid: got result %0d expected no result", i, result_s[i]);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk($sformatf("u%0d sb instance", i), i, e.inst);
                        chk($sformatf("u%0d sb result", i), int'(result_s[i]), e.res);
                        chk($sformatf("u%0d sb carry", i), int'(carry_s[i]), e.car);
                        chk($sformatf("u%0d sb ovf", i), int'(ovf_s[i]), e.ovf);
                        $display("u%0d result=%0d carry=%0d ovf=%0d", i, result_s[i], carry_s[i], ovf_s[i]);
                    end
                end
                prev_v[i] = (rvalid_s[i] === 1'b1);
                if (valid_s[i]) begin
                    chk($sformatf("u%0d add_a", i), int'(add_a_s[i]), m_acc[i]);
                    chk($sformatf("u%0d add_b", i), int'(add_b_s[i]),
                        sub_s[i] ? int'((~din_s[i]) & 4'hF) : int'(din_s[i]));
                    chk($sformatf("u%0d add_cin", i), int'(add_cin_s[i]), int'(sub_s[i]));
                end
            end
        end

        // Advance the model with the inputs the next rising edge samples.
        rst_chk = reset;
        if (reset) armed = 1'b1;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                m_acc[i]  = 0;
                m_cnt[i]  = 0;
                m_car[i]  = 0;
                m_ovf[i]  = 0;
                m_done[i] = 1'b0;
            end else if (m_done[i]) begin
                if (ack_s[i]) begin
                    m_done[i] = 1'b0;
                    m_acc[i]  = 0;
                    m_cnt[i]  = 0;
                    m_ovf[i]  = 0;
                end
            end else if (valid_s[i]) begin
                int a, d, sa, sd, u, sr;
                a  = m_acc[i];
                d  = int'(din_s[i]);
                sa = (a > 7) ? a - 16 : a;
                sd = (d > 7) ? d - 16 : d;
                if (sub_s[i]) begin
                    u  = a + 16 - d;
                    sr = sa - sd;
                end else begin
                    u  = a + d;
                    sr = sa + sd;
                end
                m_car[i] = (u >= 16) ? 1 : 0;
                if (sr > 7 || sr < -8) m_ovf[i] = 1;
                m_acc[i] = u % 16;
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == n_of(i)) begin
                    m_done[i] = 1'b1;
                    sb_q.push_back('{i, m_acc[i], m_car[i], m_ovf[i]});
                end
            end
        end

        if (fin_req && !fin_done) begin
            chk("scoreboard drained", sb_q.size(), 0);
            fin_done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus (all drives happen 1 time unit after a rising edge)
    // ------------------------------------------------------------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int d, input bit sub);
        int guard;
        din_s[i]   = 4'(d);
        sub_s[i]   = sub;
        valid_s[i] = 1'b1;
        guard = 0;
        forever begin
            @(negedge clk);
            if (ready_s[i] === 1'b1) break;
            guard++;
            if (guard > 50) begin
                $display("FAIL u%0d send timeout: got no din_ready expected ready within 50 cycles", i);
                $fatal(1);
            end
        end
        step(1);
        valid_s[i] = 1'b0;
    endtask

    task automatic wait_result(input int i);
        int guard;
        guard = 0;
        while (rvalid_s[i] !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                $display("FAIL u%0d result timeout: got no result_valid expected within 50 cycles", i);
                $fatal(1);
            end
        end
        step(1);
    endtask

    task automatic ack(input int i, input int hold);
        wait_result(i);
        step(hold);
        ack_s[i] = 1'b1;
        step(1);
        ack_s[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            din_s[i]   = '0;
            sub_s[i]   = 1'b0;
            valid_s[i] = 1'b0;
            ack_s[i]   = 1'b0;
        end
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);

        // N=2 directed: 3+5, 7-2, 15+1
        send(0, 3, 0);  send(0, 5, 0);  ack(0, 0);
        send(0, 7, 0);  send(0, 2, 1);  ack(0, 1);
        send(0, 15, 0); send(0, 1, 0);  ack(0, 0);

        // Backpressure: din 6 held while the result waits, then ack with valid.
        send(0, 4, 0);  send(0, 9, 1);
        wait_result(0);
        din_s[0]   = 4'd6;
        sub_s[0]   = 1'b0;
        valid_s[0] = 1'b1;
        step(5);
        ack_s[0] = 1'b1;
        step(1);
        ack_s[0] = 1'b0;
        send(0, 6, 0);
        send(0, 3, 0);
        ack(0, 0);

        // N=3: reset mid-collect discards the partial accumulation.
        send(1, 9, 0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(2);
        send(1, 1, 0); send(1, 2, 0); send(1, 3, 0);
        ack(1, 0);

        // N=1: every accepted operand is a result.
        for (int k = 0; k < 3; k++) begin
            send(2, 4, 0);
            ack(2, k);
        end

        // Randomised transactions on each instance.
        for (int i = 0; i < NI; i++) begin
            for (int t = 0; t < 15; t++) begin
                for (int k = 0; k < n_of(i); k++) begin
                    step($urandom_range(0, 2));
                    send(i, $urandom_range(0, 15), 1'($urandom_range(0, 1)));
                end
                ack(i, $urandom_range(0, 3));
            end
        end

        step(3);
        fin_req = 1'b1;
        step(3);
        if (!fin_done) begin
            $display("FAIL final check: got no scoreboard drain check expected one");
            $fatal(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
